// File: rtl/lcd_controller.sv
// lcd_controller: power-up delay, HD44780 init player and two-port arbiter in front of a 4-bit LCD driver
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   a_req/a_data/a_ack   character-write port: level request, ASCII byte, one-cycle done pulse
//   b_req/b_cmd/b_ack    raw-command port: level request, command byte, one-cycle done pulse
//   drv_data/drv_valid/drv_is_cmd/drv_ready
//                        driver handshake: byte, one-cycle start strobe, command flag, driver ready
//   init_done            high once the init list has been played
//   busy                 high in every state except IDLE
//   cur_col/cur_row      tracked cursor position
//
// Build option: define LCD_CURSOR_TRACK_EN to track the cursor and insert automatic
// line-wrap commands. Without it, cur_col/cur_row read 0 and no wrap commands are issued.
module lcd_controller #(
    parameter int POWERUP_CYCLES = 750000,
    parameter int COLS           = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_req,
    input  logic [7:0] a_data,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [7:0] b_cmd,
    output logic       b_ack,
    output logic [7:0] drv_data,
    output logic       drv_valid,
    output logic       drv_is_cmd,
    input  logic       drv_ready,
    output logic       init_done,
    output logic       busy,
    output logic [3:0] cur_col,
    output logic       cur_row
);
    localparam int CW = POWERUP_CYCLES > 1 ? $clog2(POWERUP_CYCLES) : 1;

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, ISSUE, WAIT_LO, WAIT_HI} state_t;
    // Who owns the transfer in flight; decides what happens when it completes.
    typedef enum logic [1:0] {K_INIT, K_A, K_B, K_WRAP} kind_t;

    state_t          state;
    kind_t           kind;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic            last_a;
    logic            grant_a;
    logic [7:0]      init_byte;

    // Round robin: A wins unless B is also waiting and A had the previous grant.
    assign grant_a = a_req && (!b_req || !last_a);
    assign busy    = state != IDLE;

    always_comb begin
        init_byte = idx == 3'd0 ? 8'h33 :
                    idx == 3'd1 ? 8'h32 :
                    idx == 3'd2 ? 8'h28 :
                    idx == 3'd3 ? 8'h0C :
                    idx == 3'd4 ? 8'h06 : 8'h01;
    end

`ifdef LCD_CURSOR_TRACK_EN
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    logic [3:0] col;
    logic       row;
    assign cur_col = col;
    assign cur_row = row;
`else
    assign cur_col = 4'd0;
    assign cur_row = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PWRUP;
            kind       <= K_INIT;
            cnt        <= '0;
            idx        <= 3'd0;
            last_a     <= 1'b0;
            drv_data   <= 8'h00;
            drv_valid  <= 1'b0;
            drv_is_cmd <= 1'b1;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            init_done  <= 1'b0;
`ifdef LCD_CURSOR_TRACK_EN
            col        <= 4'd0;
            row        <= 1'b0;
`endif
        end else begin
            drv_valid <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            case (state)
                PWRUP: begin
                    if (cnt == CW'(POWERUP_CYCLES - 1))
                        state <= INIT;
                    else
                        cnt <= cnt + 1'b1;
                end
                INIT: begin
                    drv_data   <= init_byte;
                    drv_is_cmd <= 1'b1;
                    kind       <= K_INIT;
                    drv_valid  <= drv_ready;
                    state      <= ISSUE;
                end
                IDLE: begin
                    // While an ack is showing, the requester has not yet dropped req.
                    if (!a_ack && !b_ack && (a_req || b_req)) begin
                        drv_data   <= grant_a ? a_data : b_cmd;
                        drv_is_cmd <= !grant_a;
                        kind       <= grant_a ? K_A : K_B;
                        last_a     <= grant_a;
                        drv_valid  <= drv_ready;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The strobe is one cycle wide; a stalled entry re-arms it once ready returns.
                    if (drv_valid)
                        state <= WAIT_LO;
                    else
                        drv_valid <= drv_ready;
                end
                WAIT_LO: begin
                    if (!drv_ready)
                        state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (drv_ready) begin
                        state <= IDLE;
                        case (kind)
                            K_INIT: begin
                                if (idx == 3'd5) begin
                                    init_done <= 1'b1;
`ifdef LCD_CURSOR_TRACK_EN
                                    col       <= 4'd0;
                                    row       <= 1'b0;
`endif
                                end else begin
                                    idx   <= idx + 3'd1;
                                    state <= INIT;
                                end
                            end
                            K_A: begin
`ifdef LCD_CURSOR_TRACK_EN
                                if (col == LAST_COL) begin
                                    // Line full: move the display cursor to the other row before acking.
                                    col        <= 4'd0;
                                    row        <= !row;
                                    drv_data   <= row ? 8'h80 : 8'hC0;
                                    drv_is_cmd <= 1'b1;
                                    kind       <= K_WRAP;
                                    drv_valid  <= drv_ready;
                                    state      <= ISSUE;
                                end else begin
                                    col   <= col + 4'd1;
                                    a_ack <= 1'b1;
                                end
`else
                                a_ack <= 1'b1;
`endif
                            end
                            K_B: begin
`ifdef LCD_CURSOR_TRACK_EN
                                if (drv_data == 8'h01 || drv_data == 8'h02) begin
                                    col <= 4'd0;
                                    row <= 1'b0;
                                end else if (drv_data[7]) begin
                                    col <= drv_data[3:0] > LAST_COL ? LAST_COL : drv_data[3:0];
                                    row <= drv_data[6];
                                end
`endif
                                b_ack <= 1'b1;
                            end
                            K_WRAP: a_ack <= 1'b1;
                        endcase
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end
endmodule

// File: doc/lcd_controller.md
Name: lcd_controller

Overview:
Sequencer and arbiter in front of the 4-bit LCD driver. After power-up it waits a fixed delay, then plays a fixed HD44780 init command list through the driver. After init it shares the driver between two requesters: a character-write port (A) and a raw-command port (B). It tracks the cursor so a 16x2 display wraps lines automatically.

Parameters:
POWERUP_CYCLES, 750000, clk cycles held in PWRUP before the first init command (15 ms at 50 MHz).
COLS, 16, characters per display row.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
a_req  in  1  character write request, level, held until a_ack
a_data  in  8  ASCII character for port A
a_ack  out  1  one-cycle pulse: port A transfer complete
b_req  in  1  command request, level, held until b_ack
b_cmd  in  8  LCD command byte for port B
b_ack  out  1  one-cycle pulse: port B transfer complete
drv_data  out  8  byte to driver data_in
drv_valid  out  1  one-cycle start strobe to driver data_valid
drv_is_cmd  out  1  to driver is_cmd: 1 = command, 0 = character
drv_ready  in  1  driver ready
init_done  out  1  high once the init list has completed
busy  out  1  high in every state except IDLE
cur_col  out  4  current cursor column, 0..COLS-1
cur_row  out  1  current cursor row

Behaviour:
- Reset (async, reset_n=0): state=PWRUP; delay counter, init index, cur_col, cur_row all 0; drv_valid=0; drv_data=0; drv_is_cmd=1; a_ack=b_ack=0; init_done=0; busy=1.
- Reset asserted mid-transfer aborts the transfer at once, with no ack. The init list restarts from PWRUP after release.
- PWRUP: count to POWERUP_CYCLES-1, then go to INIT.
- INIT: issue init list entry idx in the order 0x33, 0x32, 0x28, 0x0C, 0x06, 0x01, all with is_cmd=1. After entry 5 completes: init_done=1, cursor=(0,0), go to IDLE.
- Transfer (ISSUE -> WAIT_LO -> WAIT_HI):
  - ISSUE drives drv_valid=1 for exactly one cycle, and only when drv_ready=1; otherwise it stalls in ISSUE.
  - WAIT_LO waits for drv_ready=0.
  - WAIT_HI waits for drv_ready=1, then the transfer is complete.
  - drv_data and drv_is_cmd are registered and held constant from ISSUE until the transfer completes; the driver samples is_cmd late.
  - drv_valid is never asserted outside ISSUE.
- IDLE arbitration: one two-way round-robin pointer, reset value favours A.
  - Only one requester -> grant it.
  - Both requesting -> grant the one not granted last.
  - Grant is latched; a_data/b_cmd are captured in the cycle the grant is taken.
- Ack: a_ack or b_ack pulses for one cycle in the cycle after the granted transfer completes. When a wrap command follows, the ack comes after the wrap command instead.
- Cursor update on completion of a port-A character: col+1.
  - When col reaches COLS: col=0, row toggles, and the controller issues an internal wrap command through the same transfer path before acking. The command is 0xC0 if the new row is 1, 0x80 if 0.
  - The wrap command is not preemptible.
- Cursor update on completion of a port-B command:
  - 0x01 or 0x02 -> cursor (0,0).
  - cmd[7]=1 -> col=cmd[3:0] (clamped to COLS-1), row=cmd[6].
  - Any other command -> cursor unchanged.
- Requests arriving before init_done are held off, not acked.
- A requester that drops req before ack is a protocol violation and has no defined response.
- Latency: IDLE with drv_ready=1 -> drv_valid in the next cycle (one-cycle grant register).

Optional Feature:
LCD_CURSOR_TRACK_EN:
- Defined: cursor tracking, automatic wrap commands and the cur_col/cur_row updates as above.
- Undefined: no wrap commands are ever inserted. Port-A acks come directly after the character transfer. cur_col and cur_row are tied to 0. Port-B commands are passed through unchanged.

Test Plan:
- Release reset with POWERUP_CYCLES=100 and a driver model -> no drv_valid before cycle 100; six command transfers 0x33, 0x32, 0x28, 0x0C, 0x06, 0x01 with drv_is_cmd=1; then init_done=1.
- After init, a_req with a_data=0x41 -> one drv_valid with drv_data=0x41, drv_is_cmd=0; a_ack one cycle after drv_ready returns high; cur_col=1.
- 16 consecutive port-A characters (macro on) -> after the 16th character, an extra command 0xC0 is issued before the 16th a_ack; then cur_col=0, cur_row=1. With the macro off -> no 0xC0.
- a_req and b_req (b_cmd=0x01) both held from IDLE -> grant order A, B, A, B…; after the 0x01 transfer, cursor=(0,0).
- b_cmd=0xC5 -> cur_col=5, cur_row=1; b_cmd=0x9F -> cur_col=15, cur_row=0.
- Pull reset_n low during WAIT_LO of a port-A transfer -> all outputs at reset values at once, no a_ack; after release the full init list replays.
